multi_mode_timekeeper: RTL

MULTI_MODE_TIMEKEEPER -- requirements
Module: multi_mode_timekeeper

---
 rtl/timekeeper_pkg.sv | 39 +++
 rtl/tk_counter.sv | 89 ++++++++
 rtl/multi_mode_timekeeper.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/timekeeper_pkg.sv
// Shared types for the multi-mode timekeeper.
// Mode and field selects, time record, BCD helpers.
package timekeeper_pkg;

  typedef enum logic [1:0] {
    MODE_CLK = 2'b00,
    MODE_SW  = 2'b01,
    MODE_CD  = 2'b10,
    MODE_ALM = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    FLD_SEC  = 2'b00,
    FLD_MIN  = 2'b01,
    FLD_HOUR = 2'b10,
    FLD_NONE = 2'b11
  } field_e;

  typedef struct packed {
    logic [6:0] hh;
    logic [5:0] mm;
    logic [5:0] ss;
    logic [6:0] cs;
  } time_t;

  function automatic logic [7:0] bcd2(input logic [6:0] v);
    logic [3:0] t;
    logic [3:0] o;
    t = 4'(v / 7'd10);
    o = 4'(v % 7'd10);
    return {t, o};
  endfunction

  function automatic logic [31:0] to_bcd(input time_t r);
    return {bcd2(r.hh), bcd2({1'b0, r.mm}),
            bcd2({1'b0, r.ss}), bcd2(r.cs)};
  endfunction

endpackage

// File: rtl/tk_counter.sv
// One hh:mm:ss:cs record counting up or down.
// Load beats adjust, adjust beats a step.
module tk_counter
  import timekeeper_pkg::*;
#(
  parameter int    HMOD = 24,
  parameter bit    DOWN = 1'b0,
  parameter time_t INIT = '0
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   step,
  input  logic   load,
  input  logic   adj,
  input  field_e field,
  output time_t  t
);

  localparam logic [6:0] HMAX = 7'(HMOD - 1);

  time_t nxt;

  // next value: load, adjust, or one step with carry/borrow
  always_comb begin
    nxt = t;
    if (load) begin
      nxt = INIT;
    end else if (adj) begin
      unique case (field)
        FLD_SEC: begin
          nxt.ss = (t.ss == 6'd59) ? 6'd0 : t.ss + 6'd1;
          nxt.cs = '0;
        end
        FLD_MIN: begin
          nxt.mm = (t.mm == 6'd59) ? 6'd0 : t.mm + 6'd1;
          nxt.cs = '0;
        end
        FLD_HOUR: begin
          nxt.hh = (t.hh == HMAX) ? 7'd0 : t.hh + 7'd1;
          nxt.cs = '0;
        end
        FLD_NONE: ;
      endcase
    end else if (step) begin
      if (!DOWN) begin
        if (t.cs != 7'd99) begin
          nxt.cs = t.cs + 7'd1;
        end else begin
          nxt.cs = '0;
          if (t.ss != 6'd59) begin
            nxt.ss = t.ss + 6'd1;
          end else begin
            nxt.ss = '0;
            if (t.mm != 6'd59) begin
              nxt.mm = t.mm + 6'd1;
            end else begin
              nxt.mm = '0;
              nxt.hh = (t.hh == HMAX) ? 7'd0 : t.hh + 7'd1;
            end
          end
        end
      end else begin
        if (t.cs != 7'd0) begin
          nxt.cs = t.cs - 7'd1;
        end else begin
          nxt.cs = 7'd99;
          if (t.ss != 6'd0) begin
            nxt.ss = t.ss - 6'd1;
          end else begin
            nxt.ss = 6'd59;
            if (t.mm != 6'd0) begin
              nxt.mm = t.mm - 6'd1;
            end else begin
              nxt.mm = 6'd59;
              nxt.hh = (t.hh == 7'd0) ? HMAX : t.hh - 7'd1;
            end
          end
        end
      end
    end
  end

  // record register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) t <= INIT;
    else       t <= nxt;
  end

endmodule

// File: rtl/multi_mode_timekeeper.sv
// Clock, stopwatch and countdown on a shared centisecond tick.
// Define ALARM_EN to build the alarm registers behind mode 11.
module multi_mode_timekeeper
  import timekeeper_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int TICK_HZ   = 100,
  parameter int HOUR_MOD  = 24,
  parameter int CD_INIT_H = 0,
  parameter int CD_INIT_M = 1,
  parameter int CD_INIT_S = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  mode,
  input  logic        start_stop,
  input  logic        clear,
  input  logic        adj_en,
  input  logic [1:0]  adj_field,
  input  logic        adj_inc,
  output logic [6:0]  hh,
  output logic [5:0]  mm,
  output logic [5:0]  ss,
  output logic [6:0]  cs,
  output logic [31:0] bcd,
  output logic        running,
  output logic        expired,
  output logic        tick,
  output logic        alarm
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;

  localparam time_t CD_PRESET = '{
    hh: 7'(CD_INIT_H), mm: 6'(CD_INIT_M),
    ss: 6'(CD_INIT_S), cs: 7'd0};
  localparam time_t CD_ONE = '{
    hh: 7'd0, mm: 6'd0, ss: 6'd0, cs: 7'd1};

  mode_e  m;
  field_e fld;
  logic   [DW-1:0] div;
  logic   adj_go;
  logic   clk_sel;
  logic   sw_sel;
  logic   cd_sel;
  logic   sw_run;
  logic   cd_run;
  logic   cd_zero;
  logic   cd_hit;
  time_t  clk_t;
  time_t  sw_t;
  time_t  cd_t;
  time_t  disp;

  assign m      = mode_e'(mode);
  assign fld    = field_e'(adj_field);
  assign adj_go = adj_en & adj_inc;
  assign sw_sel = (m == MODE_SW);
  assign cd_sel = (m == MODE_CD);
`ifdef ALARM_EN
  assign clk_sel = (m == MODE_CLK);
`else
  assign clk_sel = (m == MODE_CLK) | (m == MODE_ALM);
`endif

  // centisecond divider
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     div <= '0;
    else if (tick) div <= '0;
    else           div <= div + DW'(1);
  end

  assign tick = (div == DW'(DIV - 1));

  tk_counter #(
    .HMOD(HOUR_MOD), .DOWN(1'b0), .INIT('0)
  ) u_clk (
    .clk  (clk),
    .reset(reset),
    .step (tick & ~(adj_en & clk_sel)),
    .load (clear & clk_sel),
    .adj  (adj_go & clk_sel),
    .field(fld),
    .t    (clk_t)
  );

  tk_counter #(
    .HMOD(100), .DOWN(1'b0), .INIT('0)
  ) u_sw (
    .clk  (clk),
    .reset(reset),
    .step (tick & sw_run),
    .load (clear & sw_sel),
    .adj  (adj_go & sw_sel & ~sw_run),
    .field(fld),
    .t    (sw_t)
  );

  tk_counter #(
    .HMOD(100), .DOWN(1'b1), .INIT(CD_PRESET)
  ) u_cd (
    .clk  (clk),
    .reset(reset),
    .step (tick & cd_run),
    .load (clear & cd_sel),
    .adj  (adj_go & cd_sel & ~cd_run),
    .field(fld),
    .t    (cd_t)
  );

  assign cd_zero = (cd_t == '0);
  assign cd_hit  = tick & cd_run & (cd_t == CD_ONE);

  // stopwatch run flag; clear wins over start_stop
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      sw_run <= 1'b0;
    else if (clear && sw_sel)
      sw_run <= 1'b0;
    else if (start_stop && sw_sel)
      sw_run <= ~sw_run;
  end

  // countdown run and sticky expired flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cd_run  <= 1'b0;
      expired <= 1'b0;
    end else if (clear && cd_sel) begin
      cd_run  <= 1'b0;
      expired <= 1'b0;
    end else if (cd_hit) begin
      cd_run  <= 1'b0;
      expired <= 1'b1;
    end else if (start_stop && cd_sel && !cd_zero) begin
      cd_run  <= ~cd_run;
    end
  end

`ifdef ALARM_EN
  localparam int HOLD = 60 * TICK_HZ;
  localparam int HW   = $clog2(HOLD + 1);
  localparam logic [6:0] HMAX = 7'(HOUR_MOD - 1);

  logic [6:0]    alm_hh;
  logic [5:0]    alm_mm;
  logic [HW-1:0] hold;
  logic          alm_sel;
  logic          match;
  logic          match_d;
  logic          alm_q;

  assign alm_sel = (m == MODE_ALM);
  assign match   = (clk_t.hh == alm_hh) && (clk_t.mm == alm_mm)
                && (clk_t.ss == 6'd0) && (clk_t.cs == 7'd0);

  // alarm time set in mode 11
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alm_hh <= '0;
      alm_mm <= '0;
    end else if (adj_go && alm_sel) begin
      unique case (fld)
        FLD_HOUR:
          alm_hh <= (alm_hh == HMAX) ? 7'd0 : alm_hh + 7'd1;
        FLD_MIN:
          alm_mm <= (alm_mm == 6'd59) ? 6'd0 : alm_mm + 6'd1;
        default: ;
      endcase
    end
  end

  // ring on match entry for 60 s or until cleared
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alm_q   <= 1'b0;
      hold    <= '0;
      match_d <= 1'b1;
    end else begin
      match_d <= match;
      if (clear && alm_sel) begin
        alm_q <= 1'b0;
      end else if (match && !match_d) begin
        alm_q <= 1'b1;
        hold  <= '0;
      end else if (alm_q && tick) begin
        if (hold == HW'(HOLD - 1)) alm_q <= 1'b0;
        else                       hold  <= hold + HW'(1);
      end
    end
  end

  assign alarm = alm_q;
`else
  assign alarm = 1'b0;
`endif

  // displayed set and its run flag
  always_comb begin
    disp    = clk_t;
    running = 1'b1;
    unique case (m)
      MODE_CLK: begin
        disp    = clk_t;
        running = 1'b1;
      end
      MODE_SW: begin
        disp    = sw_t;
        running = sw_run;
      end
      MODE_CD: begin
        disp    = cd_t;
        running = cd_run;
      end
      MODE_ALM: begin
`ifdef ALARM_EN
        disp    = '{hh: alm_hh, mm: alm_mm,
                    ss: 6'd0, cs: 7'd0};
        running = 1'b0;
`else
        disp    = clk_t;
        running = 1'b1;
`endif
      end
    endcase
  end

  assign hh  = disp.hh;
  assign mm  = disp.mm;
  assign ss  = disp.ss;
  assign cs  = disp.cs;
  assign bcd = to_bcd(disp);

endmodule
